gray_pointer_receiver: RTL and testbench

Receive side of a gray-coded counter/pointer crossing. Synchronizes an asynchronous gray-coded bus into the local clock domain, then decodes it to binary. Reports per-cycle forward progress (delta) and flags any illegal multi-bit gray transition. Sits at the read end of any gray-coded pointer crossing, such as the far side of an async FIFO or a cross-domain frame/line counter.

---
 rtl/gray_pointer_receiver.sv | 79 +++++++
 tb/tb_gray_pointer_receiver.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/gray_pointer_receiver.sv
// Receive side of a gray-coded pointer crossing: synchronize, decode to binary,
// report per-cycle modular progress and flag multi-bit gray transitions.
module gray_pointer_receiver #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             clear_error,
    output logic             valid,
    output logic [WIDTH-1:0] binary_out,
    output logic [WIDTH-1:0] delta,
    output logic             advanced,
    output logic             skip_error
);
    localparam int PRIME_MAX = SYNC_STAGES + 1;
    localparam int CW        = $clog2(PRIME_MAX + 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic [WIDTH-1:0]                  r_g_prev;
    logic [WIDTH-1:0]                  r_bin;
    logic [WIDTH-1:0]                  r_delta;
    logic                              r_adv;
    logic                              r_err;
    logic [CW-1:0]                     r_prime;

    logic [WIDTH-1:0] w_g_s;
    logic [WIDTH-1:0] w_b_new;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_delta;
    logic             w_valid;
    logic             w_multi;

    assign w_g_s   = r_sync[SYNC_STAGES-1];
    assign w_valid = (r_prime == CW'(PRIME_MAX));
    assign w_diff  = w_g_s ^ r_g_prev;
    // Clearing the lowest set bit leaves something only if two or more bits differ.
    assign w_multi = (w_diff & (w_diff - WIDTH'(1))) != '0;
    assign w_delta = w_b_new - r_bin;

    always_comb begin
        w_b_new = '0;
        for (int i = 0; i < WIDTH; i++)
            w_b_new[i] = ^(w_g_s >> i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync   <= '0;
            r_g_prev <= '0;
            r_bin    <= '0;
            r_delta  <= '0;
            r_adv    <= 1'b0;
            r_err    <= 1'b0;
            r_prime  <= '0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], gray_in};
            r_g_prev <= w_g_s;
            r_bin    <= w_b_new;
            // Set has priority over a simultaneous clear.
            r_err    <= (w_valid && w_multi) || (r_err && !clear_error);
            if (!w_valid) begin
                r_prime <= r_prime + CW'(1);
                r_delta <= '0;
                r_adv   <= 1'b0;
            end else begin
                r_delta <= w_delta;
                r_adv   <= (w_delta != '0);
            end
        end
    end

    assign valid      = w_valid;
    assign binary_out = r_bin;
    assign delta      = r_delta;
    assign advanced   = r_adv;
    assign skip_error = r_err;
endmodule

// File: tb/tb_gray_pointer_receiver.sv
// Bench for gray_pointer_receiver: directed vector table, exhaustive walk with
// mid-run reset, and random stimulus against an input-history reference model.
module tb_gray_pointer_receiver;
    localparam int W = 8;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] gray_in = 8'h07;
    logic         clear_error = 1'b0;
    logic         valid;
    logic [W-1:0] binary_out;
    logic [W-1:0] delta;
    logic         advanced;
    logic         skip_error;

    gray_pointer_receiver #(.WIDTH(W), .SYNC_STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n), .gray_in(gray_in), .clear_error(clear_error),
        .valid(valid), .binary_out(binary_out), .delta(delta),
        .advanced(advanced), .skip_error(skip_error)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: every gray value seen at a clock edge since reset release,
    // plus the sticky error it implies.
    logic [W-1:0] hist[$];
    logic         m_err;

    typedef struct {
        logic [W-1:0] gray;
        logic         clr;
        int           edges;
        logic         e_valid;
        logic [W-1:0] e_bin;
        logic [W-1:0] e_delta;
        logic         e_adv;
        logic         e_err;
    } vec_t;

    function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
        logic [W-1:0] b = '0;
        for (int s = 0; s < W; s++) b ^= (g >> s);
        return b;
    endfunction

    function automatic logic [W-1:0] b2g(input int b);
        logic [W-1:0] v = b[W-1:0];
        return v ^ (v >> 1);
    endfunction

    function automatic logic [W-1:0] seen(input int k);
        return (k < 1) ? '0 : hist[k-1];
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        int n;
        logic [W-1:0] e_bin, e_delta;
        logic e_valid, e_adv, set;
        @(posedge clk);
        hist.push_back(gray_in);
        n = hist.size();
        e_valid = (n >= S + 1);
        e_bin   = g2b(seen(n - S));
        e_delta = '0;
        set     = 1'b0;
        if (n >= S + 2) begin
            e_delta = g2b(seen(n - S)) - g2b(seen(n - S - 1));
            set     = $countones(seen(n - S) ^ seen(n - S - 1)) > 1;
        end
        e_adv = (e_delta != 0);
        m_err = set | (m_err & ~clear_error);
        #1;
        chk("valid",      valid,      e_valid);
        chk("binary_out", binary_out, e_bin);
        chk("delta",      delta,      e_delta);
        chk("advanced",   advanced,   e_adv);
        chk("skip_error", skip_error, m_err);
    endtask

    // Asynchronous reset mid-cycle, checked before any clock edge arrives.
    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_valid", valid, 0);
        chk("rst_bin",   binary_out, 0);
        chk("rst_delta", delta, 0);
        chk("rst_adv",   advanced, 0);
        chk("rst_err",   skip_error, 0);
        hist.delete();
        m_err = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    vec_t vt[$];

    initial begin
        logic [W-1:0] cur;
        int r, hold;
        m_err = 1'b0;

        // {gray, clr, edges, valid, binary_out, delta, advanced, skip_error} after the edges
        vt.push_back('{8'h07, 0, 2, 0, 8'h00, 8'h00, 0, 0});
        vt.push_back('{8'h07, 0, 1, 1, 8'h05, 8'h00, 0, 0});
        vt.push_back('{8'h07, 0, 3, 1, 8'h05, 8'h00, 0, 0});
        vt.push_back('{8'h05, 0, 2, 1, 8'h05, 8'h00, 0, 0});
        vt.push_back('{8'h05, 0, 1, 1, 8'h06, 8'h01, 1, 0});
        vt.push_back('{8'h05, 0, 1, 1, 8'h06, 8'h00, 0, 0});
        vt.push_back('{8'h81, 0, 3, 1, 8'hFE, 8'hF8, 1, 1});
        vt.push_back('{8'h81, 0, 1, 1, 8'hFE, 8'h00, 0, 1});
        vt.push_back('{8'h81, 1, 1, 1, 8'hFE, 8'h00, 0, 0});
        vt.push_back('{8'h80, 0, 3, 1, 8'hFF, 8'h01, 1, 0});
        vt.push_back('{8'h00, 0, 3, 1, 8'h00, 8'h01, 1, 0});
        vt.push_back('{8'h03, 0, 3, 1, 8'h02, 8'h02, 1, 1});
        vt.push_back('{8'h03, 0, 10, 1, 8'h02, 8'h00, 0, 1});
        vt.push_back('{8'h03, 1, 1, 1, 8'h02, 8'h00, 0, 0});
        vt.push_back('{8'h00, 0, 2, 1, 8'h02, 8'h00, 0, 0});
        vt.push_back('{8'h00, 1, 1, 1, 8'h00, 8'hFE, 1, 1});
        vt.push_back('{8'h00, 0, 1, 1, 8'h00, 8'h00, 0, 1});
        vt.push_back('{8'h00, 1, 1, 1, 8'h00, 8'h00, 0, 0});

        // Reset with a nonzero gray value held on the input.
        #12;
        chk("init_valid", valid, 0);
        chk("init_err", skip_error, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int v = 0; v < vt.size(); v++) begin
            gray_in = vt[v].gray;
            clear_error = vt[v].clr;
            for (int e = 0; e < vt[v].edges; e++) tick();
            chk($sformatf("vec%0d_valid", v), valid,      vt[v].e_valid);
            chk($sformatf("vec%0d_bin", v),   binary_out, vt[v].e_bin);
            chk($sformatf("vec%0d_delta", v), delta,      vt[v].e_delta);
            chk($sformatf("vec%0d_adv", v),   advanced,   vt[v].e_adv);
            chk($sformatf("vec%0d_err", v),   skip_error, vt[v].e_err);
            clear_error = 1'b0;
        end

        // Exhaustive walk through all gray codes, with a reset halfway.
        for (int i = 0; i < 256; i++) begin
            if (i == 128) begin
                do_reset();
                chk("walk_reprime_valid", valid, 0);
            end
            gray_in = b2g(i);
            for (int e = 0; e < 4; e++) tick();
            chk($sformatf("walk%0d_bin", i), binary_out, i);
            chk($sformatf("walk%0d_err", i), skip_error, 0);
        end

        // Random mostly-legal single-bit steps, occasional skips, clears and resets.
        cur = gray_in;
        for (int k = 0; k < 300; k++) begin
            r = $urandom_range(0, 29);
            if (r == 0) cur = W'($urandom);
            else if (r == 1) do_reset();
            else cur[$urandom_range(0, W-1)] ^= 1'b1;
            gray_in = cur;
            clear_error = ($urandom_range(0, 7) == 0);
            hold = $urandom_range(1, 4);
            for (int e = 0; e < hold; e++) begin
                tick();
                clear_error = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
